// File: rtl/gate_sequencer_if.sv
// Signal bundle between the gate sequencer and its host / gate-under-test harness.
// The slave modport is the sequencer's view; the master modport is the environment's view.
interface gate_sequencer_if;
   localparam int unsigned TBL_W = 4;

   logic             start;
   logic             abort;
   logic [TBL_W-1:0] expected;
   logic             dut_in_1;
   logic             dut_in_0;
   logic             dut_out_0;
   logic             busy;
   logic             done;
   logic             pass;
   logic [TBL_W-1:0] table_out;

   modport master (
      output start, abort, expected, dut_out_0,
      input  dut_in_1, dut_in_0, busy, done, pass, table_out
   );

   modport slave (
      input  start, abort, expected, dut_out_0,
      output dut_in_1, dut_in_0, busy, done, pass, table_out
   );
endinterface

// File: rtl/gate_sequencer.sv
// Walks a 2-input gate through its four input vectors, settles, samples the output,
// and compares the measured truth table against a latched expected table.
module gate_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input logic             clk,
   input logic             rst_n,
   gate_sequencer_if.slave bus
);
   localparam int unsigned CNT_W      = 8;
   localparam int unsigned IDX_W      = 2;
   localparam int unsigned TBL_W      = 4;
   localparam int unsigned SETTLE_EFF = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_EFF - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TBL_W - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [TBL_W-1:0] exp_q, exp_d;
   logic [TBL_W-1:0] tbl_q, tbl_d;
   logic             pass_q, pass_d;
   logic [1:0]       din_q, din_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // State register; every output is a flop so reset clears them without a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         exp_q   <= '0;
         tbl_q   <= '0;
         pass_q  <= 1'b0;
         din_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         exp_q   <= exp_d;
         tbl_q   <= tbl_d;
         pass_q  <= pass_d;
         din_q   <= din_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next state; outputs are derived from the next state so they line up with it.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      exp_d   = exp_q;
      tbl_d   = tbl_q;
      pass_d  = pass_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               exp_d   = bus.expected;
               tbl_d   = '0;
               pass_d  = 1'b0;
               idx_d   = '0;
               cnt_d   = '0;
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            if (bus.abort) begin
               pass_d  = 1'b0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_LAST) begin
                  state_d = SAMPLE;
               end
            end
         end
         SAMPLE: begin
            // Abort wins over the capture so a cancelled vector leaves no trace.
            if (bus.abort) begin
               pass_d  = 1'b0;
               state_d = IDLE;
            end else begin
               tbl_d[idx_q] = bus.dut_out_0;
               cnt_d        = '0;
               if (idx_q == IDX_LAST) begin
                  pass_d  = (tbl_d == exp_q);
                  state_d = DONE;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = SETTLE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
      done_d = (state_d == DONE);
      din_d  = busy_d ? idx_d : 2'b00;
   end

   assign bus.dut_in_1  = din_q[1];
   assign bus.dut_in_0  = din_q[0];
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.pass      = pass_q;
   assign bus.table_out = tbl_q;

endmodule

// File: doc/gate_sequencer.md
GATE_SEQUENCER -- requirements
Module: gate_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4, SHALL set the cycles each input vector is held before sampling; legal range 1..255, and a value of 0 SHALL behave as 1.
REQ-002 Port clk, input, 1, SHALL be the single clock; all state changes on its rising edge.
REQ-003 Port rst_n, input, 1, SHALL be the reset, asynchronous and active-low.
REQ-004 Port start, input, 1, SHALL request one truth-table scan; sampled only in IDLE.
REQ-005 Port abort, input, 1, SHALL be a synchronous cancel of a running scan.
REQ-006 Port expected, input, 4, SHALL be the expected truth table; bit i is the expected gate output for {in_1,in_0}=i.
REQ-007 Port dut_in_1, output, 1, SHALL drive gate input in_1 (registered).
REQ-008 Port dut_in_0, output, 1, SHALL drive gate input in_0 (registered).
REQ-009 Port dut_out_0, input, 1, SHALL be the gate output under test.
REQ-010 Port busy, output, 1, SHALL be high in SETTLE and SAMPLE.
REQ-011 Port done, output, 1, SHALL be a one-cycle completion pulse.
REQ-012 Port pass, output, 1, SHALL indicate that the last completed scan matched expected.
REQ-013 Port table_out, output, 4, SHALL hold the last measured truth table.

Function
REQ-014 States SHALL be IDLE, SETTLE, SAMPLE and DONE, with a 2-bit vector index idx and a settle counter of 8 bits.
REQ-015 In IDLE with start=1 at edge k, the block SHALL latch expected, clear table_out and pass, set idx=0 and counter=0, and enter SETTLE.
REQ-016 In SETTLE, {dut_in_1,dut_in_0} SHALL equal idx, and the counter SHALL increment each cycle; when counter==SETTLE_CYCLES-1 the block SHALL enter SAMPLE, so SETTLE lasts exactly SETTLE_CYCLES cycles.
REQ-017 In SAMPLE (1 cycle), the block SHALL keep driving idx, capture dut_out_0 into table_out[idx], and clear the counter.
REQ-018 From SAMPLE with idx<3, the block SHALL increment idx and return to SETTLE; with idx==3, it SHALL enter DONE with no wrap of idx.
REQ-019 In DONE (1 cycle), done SHALL be 1, busy SHALL be 0, and pass SHALL be set to (table_out==latched expected); the block SHALL then return to IDLE.
REQ-020 Latency: done SHALL be high in the cycle following edge k+4*(SETTLE_CYCLES+1).
REQ-021 Outside SETTLE and SAMPLE, dut_in_1 and dut_in_0 SHALL be 0.
REQ-022 start SHALL be ignored in SETTLE, SAMPLE and DONE; start held high SHALL begin a new scan from the IDLE cycle after DONE.
REQ-023 A change to expected during a scan SHALL NOT affect the result.
REQ-024 abort=1 in SETTLE or SAMPLE SHALL force IDLE at the next edge, with no done pulse, pass=0, table_out retaining partial captures, and inputs driven to 00.
REQ-025 abort SHALL take priority over start and over the SAMPLE capture in the same cycle; abort in IDLE or DONE SHALL have no effect.
REQ-026 pass and table_out SHALL hold their values until the next accepted start.

Reset
REQ-027 rst_n=0 SHALL immediately and asynchronously force IDLE, idx=0, counter=0, dut_in_1=0, dut_in_0=0, busy=0, done=0, pass=0 and table_out=0000, including mid-scan.
REQ-028 After rst_n deasserts, the block SHALL remain in IDLE until start is sampled high.

Verification
REQ-029 AND-gate model, SETTLE_CYCLES=4, expected=1000, one-cycle start -> inputs step 00,01,10,11 at 5-cycle intervals; done pulses 20 cycles after the start edge; table_out=1000; pass=1.
REQ-030 Same model with expected=0110 -> done at the same cycle; table_out=1000; pass=0.
REQ-031 start pulsed again in vector 2's SETTLE -> ignored; exactly one done pulse, at cycle 20.
REQ-032 abort during idx=2 SAMPLE -> IDLE next cycle; no done; pass=0; table_out bit2 not written; inputs 00.
REQ-033 rst_n low during idx=1 SETTLE -> all outputs zero without waiting for a clock edge; a fresh start afterwards completes normally with pass=1.
REQ-034 start held high continuously, SETTLE_CYCLES=1 -> done pulses every 10 cycles (8 scan cycles + DONE + IDLE).
